stone_age_rdr: RTL

STONE_AGE_RDR -- requirements
Module: stone_age_rdr

---
 rtl/stone_age_rdr.sv | 130 +++++++++++++
 1 files changed

// File: rtl/stone_age_rdr.sv
// ============================================================================
// Module   : stone_age_rdr
// Purpose  : Serial tally (thermometer) code to binary count converter.
//            Optional legality checking enabled by macro STONE_AGE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stone_age_rdr #(
    parameter int DIV = 1
) (
    input  logic        CLK,
    input  logic        CLR_N,
    input  logic        START,
    input  logic [14:0] Num_in_StoneAge_Binary,
    output logic [3:0]  Num_in_Binary,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    localparam int STEP_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [STEP_W-1:0] STEP_RELOAD = STEP_W'(DIV - 1);
    localparam logic [3:0] LAST_IDX = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    logic [14:0]         shreg;
    logic [3:0]          count;
    logic [3:0]          idx;
    logic [STEP_W-1:0]   step;

    logic                bit_now;
    logic [3:0]          count_next;

    assign bit_now    = shreg[0];
    assign count_next = count + {3'b000, bit_now};

`ifdef STONE_AGE_CHECK_EN
    logic zero_seen;
    logic illegal;
    logic illegal_next;

    // A mark after a gap means the code is not a contiguous tally.
    assign illegal_next = illegal | (bit_now & zero_seen);
`endif

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state         <= S_IDLE;
            shreg         <= '0;
            count         <= '0;
            idx           <= '0;
            step          <= '0;
            Num_in_Binary <= '0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            ERR           <= 1'b0;
`ifdef STONE_AGE_CHECK_EN
            zero_seen     <= 1'b0;
            illegal       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        shreg     <= Num_in_StoneAge_Binary;
                        count     <= '0;
                        idx       <= '0;
                        step      <= STEP_RELOAD;
                        BUSY      <= 1'b1;
                        state     <= S_SCAN;
`ifdef STONE_AGE_CHECK_EN
                        zero_seen <= 1'b0;
                        illegal   <= 1'b0;
`endif
                    end
                end

                S_SCAN: begin
                    if (step != '0) begin
                        step <= step - 1'b1;
                    end else begin
                        step  <= STEP_RELOAD;
                        shreg <= shreg >> 1;
                        count <= count_next;
`ifdef STONE_AGE_CHECK_EN
                        zero_seen <= zero_seen | ~bit_now;
                        illegal   <= illegal_next;
`endif
                        if (idx == LAST_IDX) begin
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            state <= S_DONE;
`ifdef STONE_AGE_CHECK_EN
                            Num_in_Binary <= illegal_next ? 4'd0 : count_next;
                            ERR           <= illegal_next;
`else
                            Num_in_Binary <= count_next;
                            ERR           <= 1'b0;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    DONE  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
